led_activity_sched: RTL
=======================

LED_ACTIVITY_SCHED -- requirements
Module: led_activity_sched

Interface
REQ-001 Parameter TICK_WIDTH, default 17, sets the tick prescaler: one tick every 2^TICK_WIDTH clocks.
REQ-002 Parameter ON_TICKS, default 3, sets the LED-on phase length in ticks (4-bit, 1..15).
REQ-003 Parameter OFF_TICKS, default 2, sets the forced-dark gap length in ticks (4-bit, 1..15).
REQ-004 Port clk, input, 1: the single clock; all state in this block changes on its rising edge.
REQ-005 Port resetn, input, 1: reset, asynchronous assertion, active-low.
REQ-006 Ports in_evt / out_evt, input, 16 each: single-cycle MIDI port activity strobes from the router.
REQ-007 Port host_valid, input, 1: host override request.
REQ-008 Port host_in / host_out, input, 16 each: host override LED pattern.
REQ-009 Port host_ticks, input, 8: host override duration in ticks.
REQ-010 Port host_ready, output, 1: this block accepts an override.
REQ-011 Port led_in / led_out, output, 16 each, registered: feed the 74HC594 LED driver in/out inputs.
REQ-012 Port ovr_active, output, 1: override in progress.

Function
REQ-013 Tick: free-running TICK_WIDTH-bit counter; tick is a one-cycle pulse on the cycle the counter equals all-ones; the counter wraps to 0.
REQ-014 Each of the 32 channels (16 in, 16 out) has an independent FSM with states IDLE, ON and OFF, a 4-bit count and a pending bit.
REQ-015 IDLE: led=0; on evt go to ON, count=ON_TICKS, pending=0.
REQ-016 ON: led=1; an evt sets pending; on tick decrement count; on a tick with count==1 go to OFF, count=OFF_TICKS.
REQ-017 OFF: led=0; an evt sets pending; on a tick with count==1, go to ON with count=ON_TICKS and pending=0 if pending=1, else go to IDLE.
REQ-018 An evt on the same cycle as a tick in IDLE loads ON_TICKS; that tick is not counted.
REQ-019 An evt on the same cycle as expiry in OFF goes to ON.
REQ-020 Multiple evts while pending is already set are merged: one pending flash maximum.
REQ-021 Sustained traffic therefore yields a blink of period ON_TICKS+OFF_TICKS, never a constant-on LED.
REQ-022 Latency: an evt at cycle N from IDLE drives the led bit high at cycle N+1.
REQ-023 Top FSM has states RUN and OVR.
REQ-024 RUN: host_ready=1, and led_in/led_out carry the channel led bits.
REQ-025 In RUN, host_valid&&host_ready latches host_in, host_out and cnt=host_ticks; host_ticks==0 is treated as 1. The FSM then enters OVR.
REQ-026 OVR: host_ready=0, ovr_active=1, and led_in/led_out carry the latched pattern starting the cycle after the handshake.
REQ-027 In OVR, cnt decrements on each tick; on a tick with cnt==1, return to RUN, and the channel bits reappear the next cycle.
REQ-028 Channel FSMs keep running during OVR, so events are not lost; only output selection changes.
REQ-029 host_valid asserted during OVR is ignored and not queued; the host must hold valid until ready.
REQ-030 Counts never underflow: a count of 0 is unreachable outside reset.

Reset
REQ-031 While resetn=0, the block asynchronously forces: led_in=0, led_out=0, host_ready=0, ovr_active=0, all channels IDLE with pending=0, top FSM RUN, prescaler=0.
REQ-032 host_ready rises on the first clk edge after resetn deasserts.
REQ-033 Reset mid-override or mid-flash abandons that state immediately; no stale pending flash survives reset.

Structure
REQ-034 The shared package holds the channel state encoding (IDLE, ON, OFF), the top state encoding (RUN, OVR), and the channel count constant 16.
REQ-035 One sub-module, led_chan_sched, holds the per-channel FSM; it takes tick and evt and produces led, and is instantiated 32 times.
REQ-036 The prescaler, override FSM and output muxing stay in the top module.

Verification (TICK_WIDTH=3, ON_TICKS=3, OFF_TICKS=2)
REQ-037 A single in_evt[4] pulse -> led_in[4]=1 from the next cycle for 3 ticks, then 0; it stays 0 with no further events.
REQ-038 out_evt[15] pulsed every 4 clocks for 200 clocks -> led_out[15] repeats 3 ticks on / 2 ticks off; no on-phase exceeds 3 ticks.
REQ-039 in_evt[0] on the tick cycle from IDLE -> on for exactly 3 subsequent ticks.
REQ-040 host_valid with host_in=16'hAAAA, host_out=16'h5555, host_ticks=2 -> handshake, then outputs show the pattern with ovr_active=1 for 2 ticks; events pulsed during OVR appear after return to RUN.
REQ-041 host_ticks=0 -> the override lasts 1 tick.
REQ-042 resetn pulsed low mid-OVR with pending set -> all outputs 0 immediately; after release, host_ready=1 one cycle later and no flash occurs without a new evt.

Source files
------------

// File: rtl/led_activity_sched_pkg.sv
// Shared encodings for the LED activity scheduler: channel FSM states, override FSM
// states and the per-direction channel count.
package led_activity_sched_pkg;

   localparam int unsigned NumChan = 16;

   typedef enum logic [1:0] {
      ChIdle,
      ChOn,
      ChOff
   } chan_state_e;

   typedef enum logic {
      TopRun,
      TopOvr
   } top_state_e;

endpackage

// File: rtl/led_chan_sched.sv
// One LED channel: flashes for ON_TICKS, then forces OFF_TICKS of dark so that
// sustained traffic blinks instead of holding the LED solid.
module led_chan_sched
   import led_activity_sched_pkg::*;
#(
   parameter int unsigned ON_TICKS  = 3,
   parameter int unsigned OFF_TICKS = 2
) (
   input  logic clk,
   input  logic resetn,
   input  logic tick,
   input  logic evt,
   output logic led
);

   localparam logic [3:0] OnLoad  = 4'(ON_TICKS);
   localparam logic [3:0] OffLoad = 4'(OFF_TICKS);

   chan_state_e state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        pend_q, pend_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pend_d  = pend_q;
      unique case (state_q)
         ChIdle: begin
            if (evt) begin
               state_d = ChOn;
               cnt_d   = OnLoad;
               pend_d  = 1'b0;
            end
         end
         ChOn: begin
            if (evt) pend_d = 1'b1;
            if (tick) begin
               if (cnt_q == 4'd1) begin
                  state_d = ChOff;
                  cnt_d   = OffLoad;
               end else begin
                  cnt_d = cnt_q - 4'd1;
               end
            end
         end
         ChOff: begin
            if (evt) pend_d = 1'b1;
            if (tick) begin
               if (cnt_q == 4'd1) begin
                  // An event landing on the expiry cycle still earns a flash.
                  if (pend_q || evt) begin
                     state_d = ChOn;
                     cnt_d   = OnLoad;
                  end else begin
                     state_d = ChIdle;
                  end
                  pend_d = 1'b0;
               end else begin
                  cnt_d = cnt_q - 4'd1;
               end
            end
         end
         default: state_d = ChIdle;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= ChIdle;
         cnt_q   <= '0;
         pend_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
      end
   end

   // Next-cycle LED value; the top registers it, giving one cycle evt-to-LED latency.
   assign led = (state_d == ChOn);

endmodule

// File: rtl/led_activity_sched.sv
// LED activity scheduler: tick prescaler, 32 channel flashers and a host override
// that temporarily replaces the LED pattern driven to the 74HC594 chain.
module led_activity_sched
   import led_activity_sched_pkg::*;
#(
   parameter int unsigned TICK_WIDTH = 17,
   parameter int unsigned ON_TICKS   = 3,
   parameter int unsigned OFF_TICKS  = 2
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic [NumChan-1:0] in_evt,
   input  logic [NumChan-1:0] out_evt,
   input  logic               host_valid,
   input  logic [NumChan-1:0] host_in,
   input  logic [NumChan-1:0] host_out,
   input  logic [7:0]         host_ticks,
   output logic               host_ready,
   output logic [NumChan-1:0] led_in,
   output logic [NumChan-1:0] led_out,
   output logic               ovr_active
);

   logic [TICK_WIDTH-1:0] presc_q;
   logic                  tick;
   logic [NumChan-1:0]    chan_in, chan_out;

   assign tick = &presc_q;

   for (genvar i = 0; i < NumChan; i++) begin : g_chan
      led_chan_sched #(
         .ON_TICKS (ON_TICKS),
         .OFF_TICKS(OFF_TICKS)
      ) u_in (
         .clk   (clk),
         .resetn(resetn),
         .tick  (tick),
         .evt   (in_evt[i]),
         .led   (chan_in[i])
      );
      led_chan_sched #(
         .ON_TICKS (ON_TICKS),
         .OFF_TICKS(OFF_TICKS)
      ) u_out (
         .clk   (clk),
         .resetn(resetn),
         .tick  (tick),
         .evt   (out_evt[i]),
         .led   (chan_out[i])
      );
   end

   top_state_e         state_q, state_d;
   logic [7:0]         cnt_q, cnt_d;
   logic [NumChan-1:0] pat_in_q, pat_in_d, pat_out_q, pat_out_d;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      pat_in_d  = pat_in_q;
      pat_out_d = pat_out_q;
      unique case (state_q)
         TopRun: begin
            if (host_valid && host_ready) begin
               state_d   = TopOvr;
               cnt_d     = (host_ticks == '0) ? 8'd1 : host_ticks;
               pat_in_d  = host_in;
               pat_out_d = host_out;
            end
         end
         TopOvr: begin
            if (tick) begin
               if (cnt_q == 8'd1) state_d = TopRun;
               else               cnt_d   = cnt_q - 8'd1;
            end
         end
         default: state_d = TopRun;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         presc_q    <= '0;
         state_q    <= TopRun;
         cnt_q      <= '0;
         pat_in_q   <= '0;
         pat_out_q  <= '0;
         host_ready <= 1'b0;
         led_in     <= '0;
         led_out    <= '0;
      end else begin
         presc_q    <= presc_q + TICK_WIDTH'(1);
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         pat_in_q   <= pat_in_d;
         pat_out_q  <= pat_out_d;
         host_ready <= (state_d == TopRun);
         led_in     <= (state_d == TopOvr) ? pat_in_d  : chan_in;
         led_out    <= (state_d == TopOvr) ? pat_out_d : chan_out;
      end
   end

   assign ovr_active = (state_q == TopOvr);

endmodule
